// File: rtl/gmii_rx_frame_parser_if.sv
// GMII receive side plus parsed byte-stream outputs for gmii_rx_frame_parser.
// slave: the parser (consumes GMII, drives the stream).
// master: whoever feeds GMII and watches the stream.
`timescale 1ns/1ps
interface gmii_rx_frame_parser_if;
    logic [7:0]  gmii_rxd;
    logic        gmii_rxdv;
    logic        gmii_rxer;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sop;
    logic        rx_eop;
    logic [3:0]  rx_status;
    logic [10:0] rx_len;
    logic [15:0] rx_drop_cnt;

    modport master (
        output gmii_rxd, gmii_rxdv, gmii_rxer,
        input  rx_data, rx_valid, rx_sop, rx_eop, rx_status, rx_len, rx_drop_cnt
    );

    modport slave (
        input  gmii_rxd, gmii_rxdv, gmii_rxer,
        output rx_data, rx_valid, rx_sop, rx_eop, rx_status, rx_len, rx_drop_cnt
    );
endinterface

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive frame parser: strips preamble/SFD, forwards DA..FCS with
// sop/eop framing, length and status, and counts discarded frames.
// Optional CRC-32 check enabled by defining RX_CRC_CHECK_EN.
//
// state    | meaning
// IDLE     | between frames, waiting for dv
// PREAMBLE | receiving 0x55 bytes, waiting for SFD 0xD5
// DATA     | forwarding frame bytes through the hold register
// DROP     | discarding the rest of a bad or partial frame until dv low
`timescale 1ns/1ps
module gmii_rx_frame_parser #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input logic                  gmii_rx_clk,
    input logic                  reset,
    gmii_rx_frame_parser_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [11:0] MIN_L = 12'(MIN_FRAME_LEN);
    localparam logic [11:0] MAX_L = 12'(MAX_FRAME_LEN);

    state_t      state;
    logic [7:0]  s1_d;
    logic        s1_dv;
    logic        s1_er;
    // low for the first cycle after reset, so stale reset values in s1
    // are not mistaken for a dv-low gap
    logic        s1_loaded;

    logic [7:0]  hold_data;
    logic        hold_sop;
    logic        hold_valid;
    logic [10:0] len_cnt;
    logic        err_flag;

    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [3:0]  out_status;
    logic [10:0] out_len;
    logic [15:0] drop_cnt;

    logic        s1_ctrl_err;
    logic        runt;
    logic        oversize;
    logic        crc_err;
    logic        sfd_seen;

    assign s1_ctrl_err = s1_er ^ s1_dv;
    assign runt        = ({1'b0, len_cnt} < MIN_L);
    assign oversize    = ({1'b0, len_cnt} > MAX_L);
    assign sfd_seen    = (state == PREAMBLE) && s1_dv && (s1_d == 8'hD5);

    assign bus.rx_data     = out_data;
    assign bus.rx_valid    = out_valid;
    assign bus.rx_sop      = out_sop;
    assign bus.rx_eop      = out_eop;
    assign bus.rx_status   = out_status;
    assign bus.rx_len      = out_len;
    assign bus.rx_drop_cnt = drop_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // CRC over every DATA byte including FCS; good frames leave the magic residue
    always_ff @(posedge gmii_rx_clk or posedge reset) begin
        if (reset) begin
            crc <= 32'hFFFF_FFFF;
        end else if (sfd_seen) begin
            crc <= 32'hFFFF_FFFF;
        end else if (state == DATA && s1_dv) begin
            crc <= crc32_byte(crc, s1_d);
        end
    end

    assign crc_err = (crc != 32'hDEBB_20E3);
`else
    assign crc_err = 1'b0;
`endif

    // input register stage, no decode before this point
    always_ff @(posedge gmii_rx_clk or posedge reset) begin
        if (reset) begin
            s1_d      <= 8'd0;
            s1_dv     <= 1'b0;
            s1_er     <= 1'b0;
            s1_loaded <= 1'b0;
        end else begin
            s1_d      <= bus.gmii_rxd;
            s1_dv     <= bus.gmii_rxdv;
            s1_er     <= bus.gmii_rxer;
            s1_loaded <= 1'b1;
        end
    end

    // frame FSM with hold register, counters and registered stream outputs
    always_ff @(posedge gmii_rx_clk or posedge reset) begin
        if (reset) begin
            state      <= DROP;
            hold_data  <= 8'd0;
            hold_sop   <= 1'b0;
            hold_valid <= 1'b0;
            len_cnt    <= 11'd0;
            err_flag   <= 1'b0;
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_status <= 4'd0;
            out_len    <= 11'd0;
            drop_cnt   <= 16'd0;
        end else begin
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_status <= 4'd0;
            out_len    <= 11'd0;
            case (state)
                IDLE: begin
                    if (s1_dv) begin
                        if (s1_d == 8'h55) begin
                            state <= PREAMBLE;
                        end else begin
                            state    <= DROP;
                            drop_cnt <= sat_inc16(drop_cnt);
                        end
                    end
                end
                PREAMBLE: begin
                    if (!s1_dv) begin
                        state <= IDLE;
                    end else if (s1_d == 8'hD5) begin
                        state      <= DATA;
                        len_cnt    <= 11'd0;
                        err_flag   <= 1'b0;
                        hold_valid <= 1'b0;
                    end else if (s1_d != 8'h55) begin
                        state    <= DROP;
                        drop_cnt <= sat_inc16(drop_cnt);
                    end
                end
                DATA: begin
                    if (s1_dv) begin
                        // the previously held byte is not the last one
                        if (hold_valid) begin
                            out_valid <= 1'b1;
                            out_data  <= hold_data;
                            out_sop   <= hold_sop;
                        end
                        hold_data  <= s1_d;
                        hold_sop   <= (len_cnt == 11'd0);
                        hold_valid <= 1'b1;
                        if (len_cnt != 11'h7FF) begin
                            len_cnt <= len_cnt + 11'd1;
                        end
                        err_flag <= err_flag | s1_ctrl_err;
                    end else begin
                        state      <= IDLE;
                        hold_valid <= 1'b0;
                        if (hold_valid) begin
                            out_valid  <= 1'b1;
                            out_data   <= hold_data;
                            out_sop    <= hold_sop;
                            out_eop    <= 1'b1;
                            out_len    <= len_cnt;
                            out_status <= {crc_err, oversize, runt, err_flag | s1_ctrl_err};
                        end else begin
                            drop_cnt <= sat_inc16(drop_cnt);
                        end
                    end
                end
                DROP: begin
                    if (!s1_dv && s1_loaded) begin
                        state <= IDLE;
                    end
                end
                default: state <= DROP;
            endcase
        end
    end
endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Scoreboard bench for gmii_rx_frame_parser: stimulus pushes expected beats,
// a negedge monitor pops and compares every rx_valid beat.
`timescale 1ns/1ps
module tb_gmii_rx_frame_parser;
`ifdef RX_CRC_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic [3:0]  st;
        logic [10:0] len;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    beat_t exp_q[$];
    logic [7:0] fb [0:2047];

    gmii_rx_frame_parser_if bus();

    gmii_rx_frame_parser #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518)) dut (
        .gmii_rx_clk (clk),
        .reset       (rst),
        .bus         (bus)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal end");
        $fatal(1);
    end

    // monitor: every valid beat must match the head of the expected queue
    always @(negedge clk) begin : mon
        beat_t e;
        if (bus.rx_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got data=%h sop=%b eop=%b cyc=%0d, expected no output",
                         bus.rx_data, bus.rx_sop, bus.rx_eop, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.rx_data !== e.data || bus.rx_sop !== e.sop || bus.rx_eop !== e.eop ||
                    bus.rx_status !== e.st || bus.rx_len !== e.len || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL beat: got data=%h sop=%b eop=%b st=%b len=%0d cyc=%0d, expected data=%h sop=%b eop=%b st=%b len=%0d cyc=%0d",
                             bus.rx_data, bus.rx_sop, bus.rx_eop, bus.rx_status, bus.rx_len, cyc,
                             e.data, e.sop, e.eop, e.st, e.len, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // payload pattern followed by a correct (or corrupted) FCS
    task automatic build_frame(input int n, input int seed, input bit fcs_ok);
        logic [31:0] c;
        int np;
        c  = 32'hFFFF_FFFF;
        np = (n >= 4) ? n - 4 : n;
        for (int i = 0; i < np; i++) begin
            fb[i] = 8'((i * 7 + seed) & 255);
            c = crc_byte(c, fb[i]);
        end
        if (n >= 4) begin
            c = ~c;
            fb[np]     = c[7:0];
            fb[np + 1] = c[15:8];
            fb[np + 2] = c[23:16];
            fb[np + 3] = c[31:24];
            if (!fcs_ok) fb[n - 1] = fb[n - 1] ^ 8'hFF;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        bus.gmii_rxd  = b;
        bus.gmii_rxdv = 1'b1;
        bus.gmii_rxer = 1'b1;
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) begin
            @(negedge clk);
            bus.gmii_rxd  = 8'd0;
            bus.gmii_rxdv = 1'b0;
            bus.gmii_rxer = 1'b0;
        end
    endtask

    // preamble + SFD + fb[0..n-1]; optional control error and mid-frame reset
    task automatic drive_frame(input int n, input int er_at, input int rst_at, input logic [3:0] exp_st);
        beat_t e;
        for (int p = 0; p < 7; p++) drive_byte(8'h55);
        drive_byte(8'hD5);
        for (int i = 0; i < n; i++) begin
            if (rst_at >= 0 && i == rst_at) begin
                @(posedge clk);
                #1 rst = 1'b1;
                #1 check("valid_in_reset", {31'd0, bus.rx_valid}, 32'd0);
            end
            if (rst_at >= 0 && i == rst_at + 2) begin
                @(posedge clk);
                #1 rst = 1'b0;
            end
            @(negedge clk);
            bus.gmii_rxd  = fb[i];
            bus.gmii_rxdv = 1'b1;
            bus.gmii_rxer = (i == er_at) ? 1'b0 : 1'b1;
            if (rst_at < 0 || i + 3 < rst_at) begin
                e.data = fb[i];
                e.sop  = (i == 0);
                e.eop  = (rst_at < 0) && (i == n - 1);
                e.st   = e.eop ? exp_st : 4'd0;
                e.len  = e.eop ? 11'(n) : 11'd0;
                e.cyc  = cyc + 3;
                exp_q.push_back(e);
            end
        end
        idle(1);
    endtask

    initial begin
        bus.gmii_rxd  = 8'd0;
        bus.gmii_rxdv = 1'b0;
        bus.gmii_rxer = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid",   {31'd0, bus.rx_valid},  32'd0);
        check("rst_sop",     {31'd0, bus.rx_sop},    32'd0);
        check("rst_eop",     {31'd0, bus.rx_eop},    32'd0);
        check("rst_data",    {24'd0, bus.rx_data},   32'd0);
        check("rst_status",  {28'd0, bus.rx_status}, 32'd0);
        check("rst_len",     {21'd0, bus.rx_len},    32'd0);
        check("rst_dropcnt", {16'd0, bus.rx_drop_cnt}, 32'd0);
        rst = 1'b0;
        idle(4);

        build_frame(64, 3, 1'b1);
        drive_frame(64, -1, -1, 4'b0000);
        idle(5);

        build_frame(64, 3, 1'b0);
        drive_frame(64, -1, -1, {CRC_ON, 3'b000});
        idle(5);

        build_frame(20, 11, 1'b1);
        drive_frame(20, -1, -1, 4'b0010);
        build_frame(1600, 29, 1'b1);
        drive_frame(1600, -1, -1, 4'b0100);
        idle(5);

        build_frame(1, 90, 1'b1);
        drive_frame(1, -1, -1, {CRC_ON, 3'b010});
        idle(5);

        build_frame(64, 17, 1'b1);
        drive_frame(64, 10, -1, 4'b0001);
        idle(5);
        check("dropcnt_0", {16'd0, bus.rx_drop_cnt}, 32'd0);

        drive_byte(8'h55);
        drive_byte(8'h55);
        drive_byte(8'hAA);
        drive_byte(8'h12);
        drive_byte(8'h34);
        idle(5);
        check("dropcnt_bad_pre", {16'd0, bus.rx_drop_cnt}, 32'd1);

        for (int p = 0; p < 7; p++) drive_byte(8'h55);
        drive_byte(8'hD5);
        idle(5);
        check("dropcnt_empty", {16'd0, bus.rx_drop_cnt}, 32'd2);

        build_frame(100, 45, 1'b1);
        drive_frame(100, -1, 30, 4'b0000);
        idle(5);
        check("dropcnt_after_rst", {16'd0, bus.rx_drop_cnt}, 32'd0);

        build_frame(64, 61, 1'b1);
        drive_frame(64, -1, -1, 4'b0000);
        idle(8);
        check("dropcnt_final", {16'd0, bus.rx_drop_cnt}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
